// File: rtl/reg4_bank_arbiter_pkg.sv
// Shared sizing and the 2-bit index type used for register addresses and the
// round-robin pointer.
package reg4_bank_arbiter_pkg;
  localparam int WIDTH    = 4;
  localparam int NUM_REQ  = 4;
  localparam int NUM_REGS = 4;

  typedef logic [1:0] idx_t;
endpackage

// File: rtl/reg4_en.sv
// One bank register: async reset, synchronous clear, write enable.
module reg4_en #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/reg4_bank_arbiter.sv
// Four-register bank shared by four requesters through a round-robin arbiter;
// one access per cycle, results registered alongside the one-hot grant.
module reg4_bank_arbiter
  import reg4_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = reg4_bank_arbiter_pkg::NUM_REQ,
  parameter int WIDTH   = reg4_bank_arbiter_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [2*NUM_REQ-1:0]        addr,
  input  logic [WIDTH*NUM_REQ-1:0]    wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rvalid,
  output logic [NUM_REGS*WIDTH-1:0]   reg_q
);
  typedef struct packed {
    logic             we;
    idx_t             addr;
    logic [WIDTH-1:0] wdata;
  } acc_t;

  acc_t [NUM_REQ-1:0]               acc;
  acc_t                             sel;
  logic [NUM_REQ-1:0]               elig;
  logic [NUM_REGS-1:0][WIDTH-1:0]   bank_q;
  idx_t                             ptr, win, cand;
  logic                             hit, go, wr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_acc
      assign acc[gi].we    = we[gi];
      assign acc[gi].addr  = addr[2*gi +: 2];
      assign acc[gi].wdata = wdata[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // A requester whose grant is showing this cycle sits out one arbitration.
  assign elig = req & ~gnt;

  // Scan from the farthest offset back to ptr so the nearest eligible wins.
  always_comb begin
    hit  = 1'b0;
    win  = ptr;
    cand = ptr;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = ptr + idx_t'(k);
      if (elig[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  assign sel = acc[win];
  assign go  = hit & ~clr;
  assign wr  = go & sel.we;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
      reg4_en #(.W(WIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (wr && (sel.addr == idx_t'(gi))),
        .d   (sel.wdata),
        .q   (bank_q[gi])
      );
    end
  endgenerate

  assign reg_q = bank_q;

  // Reads capture the pre-edge register value; rdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      ptr    <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= 1'b0;
      if (go) begin
        gnt[win] <= 1'b1;
        ptr      <= win + idx_t'(1);
        if (!sel.we) begin
          rdata  <= bank_q[sel.addr];
          rvalid <= 1'b1;
        end
      end
    end
  end
endmodule
